mem_bist_reporter: RTL and testbench
====================================

// Module: mem_bist_reporter
// PURPOSE
//  Hardware memory self-test engine for the management SRAM.
//  - Runs three phases in order: word, halfword and byte write/readback.
//  - Publishes progress as 16-bit status codes on a checkbits bus. The top level routes this bus to mprj_io[31:16].
//  - This block is the producer of the code stream that the DV monitors decode.
//  - Firmware or housekeeping starts it with a pulse and reads busy/done/pass.
// PARAMETERS
//  ADDR_W      9    word-address width of the SRAM port
//  DEPTH       512  number of 32-bit words tested, 1..2**ADDR_W
//  STATUS_HOLD 16   minimum core_clk cycles each announce/pass code is held, >=1
// PORTS
//  core_clk    in   1       single clock
//  core_rstn   in   1       asynchronous assert, active-low reset
//  start       in   1       1-cycle pulse that begins a run
//  mem_en      out  1       SRAM access strobe
//  mem_we      out  4       byte write enables; 0 = read
//  mem_addr    out  ADDR_W  word address
//  mem_wdata   out  32      write data
//  mem_rdata   in   32      read data, valid exactly 1 cycle after a read strobe
//  checkbits   out  16      status code
//  busy        out  1       run in progress
//  done        out  1       run finished; held until the next start
//  pass        out  1       valid while done=1
//  fail_addr   out  ADDR_W  word index of the first mismatch
// BEHAVIOUR
//  Reset values: all outputs 0, FSM in IDLE.
//  Reset asserted mid-run: immediate return to reset values. A write in flight may be lost.
//  Status codes per phase (announce / fail / pass):
//  - word  = A040 / AB40 / AB41
//  - short = A020 / AB20 / AB21
//  - byte  = A010 / AB10 / AB11
//  Patterns, with i the unit index:
//  - word:  Pw(i) = {i[15:0]^16'h5A5A, i[15:0]}
//  - short: Ph(j) = j[15:0]^16'hC3C3
//  - byte:  Pb(k) = k[7:0]^8'h96
//  FSM: IDLE -> ANNOUNCE -> WRITE -> READ -> DRAIN -> REPORT -> next phase ANNOUNCE, or DONE after byte.
//  - IDLE: start=1 -> ANNOUNCE(word). Clears done, pass and fail_addr; sets busy.
//  - ANNOUNCE: drive the announce code for STATUS_HOLD cycles, then WRITE.
//  - WRITE, one access per cycle, mem_en=1:
//    - word: DEPTH writes, we=1111, data Pw(w).
//    - short: 2*DEPTH writes; halfword j goes to word j>>1 with we=0011 (j even) or 1100 (j odd), data {Ph(j),Ph(j)}.
//    - byte: 4*DEPTH writes; byte k goes to word k>>2 with we = 1<<(k&3), data replicated x4.
//  - READ: DEPTH reads, addresses 0..DEPTH-1 on back-to-back cycles. Each rdata is compared in the following cycle against:
//    - word:  Pw(w)
//    - short: {Ph(2w+1),Ph(2w)}
//    - byte:  {Pb(4w+3),..,Pb(4w)}
//  - DRAIN: one cycle that compares the last read.
//  - Mismatch in READ or DRAIN -> FAIL:
//    - capture fail_addr = w; drive the fail code; no further mem_en.
//    - then DONE with pass=0. Reads already issued are discarded.
//  - REPORT: drive the pass code for STATUS_HOLD cycles.
//  - DONE: busy=0, done=1, pass=1 only if all three phases passed.
//    - checkbits holds the final code (AB11 or AB?0) until the next start.
//    - start in DONE behaves as in IDLE.
//  start while busy is ignored.
//  Index counters are ADDR_W+2 bits wide. Terminal count is exact (DEPTH*units-1); no wrap past DEPTH.
//  DEPTH=1 is legal: each phase issues a single read.
//  mem_we=0 whenever mem_en=0.
//  Latency from start to first ANNOUNCE code: 1 cycle.
// STRUCTURE
//  Package mem_bist_pkg holds:
//  - state enum and phase enum
//  - the nine status-code localparams
//  - pattern XOR seeds 5A5A, C3C3, 96
//  Sub-module mem_bist_pattern (combinational):
//  - inputs: phase, index
//  - outputs: wdata, we, word addr, and the expected read word for a word index
//  - shared by the write and compare paths.
// TESTING
//  1 Ideal 1-cycle SRAM model, DEPTH=512.
//    start -> codes A040,AB41,A020,AB21,A010,AB11 in order, each held >=16 cycles; then done=1, pass=1.
//  2 Model forces bit 3 of word 7 stuck-at-1 -> checkbits AB40, fail_addr=7, pass=0, done=1, no mem_en after the fail.
//  3 Model ignores we[2] -> word phase passes (AB41); short phase ends in AB20 with fail_addr=0.
//  4 core_rstn pulsed low during the byte WRITE phase -> all outputs 0 on the same edge.
//    A later start reruns from A040 and passes.
//  5 start pulsed every cycle during a run -> no restart, same code sequence as test 1.
//    start in DONE -> done cleared, new run.
//  6 DEPTH=1, STATUS_HOLD=1 -> each phase issues exactly one read; pass=1 within 30 cycles.

Source files
------------

// File: rtl/mem_bist_pkg.sv
// Shared types, status codes and pattern seeds for the management-SRAM self-test engine.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAnnounce,
    StWrite,
    StRead,
    StDrain,
    StReport,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    PhWord,
    PhShort,
    PhByte
  } phase_e;

  localparam logic [15:0] CodeWordAnn   = 16'hA040;
  localparam logic [15:0] CodeWordFail  = 16'hAB40;
  localparam logic [15:0] CodeWordPass  = 16'hAB41;
  localparam logic [15:0] CodeShortAnn  = 16'hA020;
  localparam logic [15:0] CodeShortFail = 16'hAB20;
  localparam logic [15:0] CodeShortPass = 16'hAB21;
  localparam logic [15:0] CodeByteAnn   = 16'hA010;
  localparam logic [15:0] CodeByteFail  = 16'hAB10;
  localparam logic [15:0] CodeBytePass  = 16'hAB11;

  localparam logic [15:0] SeedWord  = 16'h5A5A;
  localparam logic [15:0] SeedShort = 16'hC3C3;
  localparam logic [7:0]  SeedByte  = 8'h96;

  function automatic logic [15:0] announce_code(phase_e ph);
    case (ph)
      PhWord:  return CodeWordAnn;
      PhShort: return CodeShortAnn;
      default: return CodeByteAnn;
    endcase
  endfunction

  function automatic logic [15:0] fail_code(phase_e ph);
    case (ph)
      PhWord:  return CodeWordFail;
      PhShort: return CodeShortFail;
      default: return CodeByteFail;
    endcase
  endfunction

  function automatic logic [15:0] pass_code(phase_e ph);
    case (ph)
      PhWord:  return CodeWordPass;
      PhShort: return CodeShortPass;
      default: return CodeBytePass;
    endcase
  endfunction

endpackage

// File: rtl/mem_bist_pattern.sv
// Combinational pattern generator: write beat for a unit index and expected readback for a word.
module mem_bist_pattern
  import mem_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = 9
) (
  input  logic [1:0]        phase_i,
  input  logic [ADDR_W+1:0] idx_i,
  input  logic [ADDR_W-1:0] chk_word_i,
  output logic [31:0]       wdata_o,
  output logic [3:0]        we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [31:0]       exp_o
);

  logic [15:0] u16;
  logic [15:0] w16;

  always_comb begin
    u16     = 16'(idx_i);
    w16     = 16'(chk_word_i);
    wdata_o = '0;
    we_o    = '0;
    addr_o  = '0;
    exp_o   = '0;
    unique case (phase_e'(phase_i))
      PhWord: begin
        wdata_o = {u16 ^ SeedWord, u16};
        we_o    = 4'b1111;
        addr_o  = idx_i[ADDR_W-1:0];
        exp_o   = {w16 ^ SeedWord, w16};
      end
      PhShort: begin
        wdata_o = {2{u16 ^ SeedShort}};
        we_o    = idx_i[0] ? 4'b1100 : 4'b0011;
        addr_o  = idx_i[ADDR_W:1];
        exp_o   = {{w16[14:0], 1'b1} ^ SeedShort, {w16[14:0], 1'b0} ^ SeedShort};
      end
      PhByte: begin
        wdata_o = {4{u16[7:0] ^ SeedByte}};
        we_o    = 4'b0001 << idx_i[1:0];
        addr_o  = idx_i[ADDR_W+1:2];
        exp_o   = {{w16[5:0], 2'd3} ^ SeedByte, {w16[5:0], 2'd2} ^ SeedByte,
                   {w16[5:0], 2'd1} ^ SeedByte, {w16[5:0], 2'd0} ^ SeedByte};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bist_reporter.sv
// Management-SRAM self-test engine: word, halfword and byte write/readback phases, with
// progress published as 16-bit status codes on checkbits.
module mem_bist_reporter
  import mem_bist_pkg::*;
#(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned STATUS_HOLD = 16
) (
  input  logic              core_clk,
  input  logic              core_rstn,
  input  logic              start,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [15:0]       checkbits,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr
);

  localparam int unsigned IdxW  = ADDR_W + 2;
  localparam int unsigned HoldW = (STATUS_HOLD > 1) ? $clog2(STATUS_HOLD) : 1;

  localparam logic [IdxW-1:0]  LastWord  = IdxW'(DEPTH - 1);
  localparam logic [IdxW-1:0]  LastShort = IdxW'(2 * DEPTH - 1);
  localparam logic [IdxW-1:0]  LastByte  = IdxW'(4 * DEPTH - 1);
  localparam logic [HoldW-1:0] HoldLast  = HoldW'(STATUS_HOLD - 1);

  state_e             state_q, state_d;
  phase_e             phase_q, phase_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic               chk_vld_q, chk_vld_d;
  logic [ADDR_W-1:0]  chk_addr_q, chk_addr_d;
  logic [15:0]        code_q, code_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [ADDR_W-1:0]  fail_addr_q, fail_addr_d;

  logic [31:0]        pat_wdata;
  logic [3:0]         pat_we;
  logic [ADDR_W-1:0]  pat_addr;
  logic [31:0]        pat_exp;
  logic [IdxW-1:0]    last_wr;
  logic               mismatch;

  mem_bist_pattern #(
    .ADDR_W(ADDR_W)
  ) u_pattern (
    .phase_i   (phase_q),
    .idx_i     (idx_q),
    .chk_word_i(chk_addr_q),
    .wdata_o   (pat_wdata),
    .we_o      (pat_we),
    .addr_o    (pat_addr),
    .exp_o     (pat_exp)
  );

  // rdata belongs to the read issued in the previous cycle, tracked by chk_vld_q/chk_addr_q
  assign mismatch = chk_vld_q && (mem_rdata != pat_exp);

  always_comb begin
    last_wr = (phase_q == PhWord) ? LastWord : (phase_q == PhShort) ? LastShort : LastByte;
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    chk_vld_d   = 1'b0;
    chk_addr_d  = chk_addr_q;
    code_d      = code_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StAnnounce;
          phase_d     = PhWord;
          hold_d      = '0;
          code_d      = announce_code(PhWord);
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_addr_d = '0;
        end
      end
      StAnnounce: begin
        if (hold_q == HoldLast) begin
          state_d = StWrite;
          idx_d   = '0;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StWrite: begin
        if (idx_q == last_wr) begin
          state_d = StRead;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StRead, StDrain: begin
        if (mismatch) begin
          state_d     = StDone;
          code_d      = fail_code(phase_q);
          fail_addr_d = chk_addr_q;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          pass_d      = 1'b0;
        end else if (state_q == StDrain) begin
          state_d = StReport;
          hold_d  = '0;
          code_d  = pass_code(phase_q);
        end else begin
          chk_vld_d  = 1'b1;
          chk_addr_d = idx_q[ADDR_W-1:0];
          if (idx_q == LastWord) begin
            state_d = StDrain;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StReport: begin
        if (hold_q != HoldLast) begin
          hold_d = hold_q + HoldW'(1);
        end else if (phase_q == PhByte) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b1;
        end else begin
          phase_d = (phase_q == PhWord) ? PhShort : PhByte;
          state_d = StAnnounce;
          hold_d  = '0;
          code_d  = announce_code((phase_q == PhWord) ? PhShort : PhByte);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // SRAM strobes decode straight from registered state so reads land on back-to-back cycles
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == StWrite) begin
      mem_en    = 1'b1;
      mem_we    = pat_we;
      mem_addr  = pat_addr;
      mem_wdata = pat_wdata;
    end else if (state_q == StRead) begin
      mem_en   = 1'b1;
      mem_addr = idx_q[ADDR_W-1:0];
    end
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      state_q     <= StIdle;
      phase_q     <= PhWord;
      idx_q       <= '0;
      hold_q      <= '0;
      chk_vld_q   <= 1'b0;
      chk_addr_q  <= '0;
      code_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      chk_vld_q   <= chk_vld_d;
      chk_addr_q  <= chk_addr_d;
      code_q      <= code_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
    end
  end

  assign checkbits = code_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;

endmodule

// File: tb/tb_mem_bist_reporter.sv
// Bench for mem_bist_reporter: SRAM model with injectable faults, memory-image reference
// model feeding a code/result scoreboard, and a small DEPTH=1 instance.
module tb_mem_bist_reporter;

  localparam int unsigned AW   = 9;
  localparam int unsigned D    = 512;
  localparam int unsigned HOLD = 16;

  typedef struct {
    logic pass;
    int   addr;
  } fin_t;

  logic          core_clk  = 1'b0;
  logic          core_rstn = 1'b0;
  logic          start     = 1'b0;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic [15:0]   checkbits;
  logic          busy, done, pass;
  logic [AW-1:0] fail_addr;

  logic          start2 = 1'b0;
  logic          mem_en2;
  logic [3:0]    mem_we2;
  logic [0:0]    mem_addr2;
  logic [31:0]   mem_wdata2;
  logic [31:0]   mem_rdata2 = '0;
  logic [15:0]   checkbits2;
  logic          busy2, done2, pass2;
  logic [0:0]    fail_addr2;

  mem_bist_reporter #(.ADDR_W(AW), .DEPTH(D), .STATUS_HOLD(HOLD)) dut (
    .core_clk(core_clk), .core_rstn(core_rstn), .start(start),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .checkbits(checkbits), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr)
  );

  mem_bist_reporter #(.ADDR_W(1), .DEPTH(1), .STATUS_HOLD(1)) dut2 (
    .core_clk(core_clk), .core_rstn(core_rstn), .start(start2),
    .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata2), .checkbits(checkbits2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_addr(fail_addr2)
  );

  always #5 core_clk = ~core_clk;

  int n_vec = 0;
  int n_err = 0;
  int en_in_done = 0;
  int we_wo_en = 0;
  int rd2[3] = '{0, 0, 0};
  int addr2_bad = 0;

  // Fault knobs: a lane dropped on partial writes, and a stuck-at-1 bit on reads
  int   ignore_lane = -1;
  int   stuck_word  = -1;
  int   stuck_bit   = 0;
  logic mem_clr     = 1'b0;

  logic [15:0] code_q[$];
  fin_t        fin_q[$];

  logic [31:0] sram[D];
  logic [31:0] sram2;
  logic [31:0] ref_m[D];
  logic [31:0] ideal_m[D];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] faulty_read(input logic [31:0] v, input int a);
    logic [31:0] r;
    r = v;
    if (a == stuck_word) r[stuck_bit] = 1'b1;
    return r;
  endfunction

  always @(posedge core_clk) begin
    if (mem_clr) begin
      for (int i = 0; i < D; i++) sram[i] <= '0;
    end else if (mem_en) begin
      if (mem_we != 4'd0) begin
        for (int b = 0; b < 4; b++)
          if (mem_we[b] && !(b == ignore_lane && mem_we != 4'hF))
            sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= faulty_read(sram[mem_addr], int'(mem_addr));
      end
    end
  end

  always @(posedge core_clk) begin
    if (mem_en2) begin
      if (mem_we2 != 4'd0) begin
        for (int b = 0; b < 4; b++)
          if (mem_we2[b]) sram2[b*8 +: 8] <= mem_wdata2[b*8 +: 8];
      end else begin
        mem_rdata2 <= sram2;
      end
    end
  end

  function automatic logic [15:0] code_of(input int p, input int kind);
    case (p * 3 + kind)
      0:       return 16'hA040;
      1:       return 16'hAB40;
      2:       return 16'hAB41;
      3:       return 16'hA020;
      4:       return 16'hAB20;
      5:       return 16'hAB21;
      6:       return 16'hA010;
      7:       return 16'hAB10;
      default: return 16'hAB11;
    endcase
  endfunction

  // Reference: replay every write into an ideal and a faulty memory image, then scan for the
  // first word whose faulty readback differs from the ideal image.
  task automatic predict();
    logic [31:0] v;
    int units, nb, w, lane;
    for (int i = 0; i < D; i++) ref_m[i] = '0;
    for (int p = 0; p < 3; p++) begin
      code_q.push_back(code_of(p, 0));
      units = 1 << p;
      nb    = 4 >> p;
      for (int u = 0; u < D * units; u++) begin
        case (p)
          0:       v = {16'(u) ^ 16'h5A5A, 16'(u)};
          1:       v = {16'h0, 16'(u) ^ 16'hC3C3};
          default: v = {24'h0, 8'(u) ^ 8'h96};
        endcase
        w = u / units;
        for (int b = 0; b < nb; b++) begin
          lane = (u % units) * nb + b;
          ideal_m[w][lane*8 +: 8] = v[b*8 +: 8];
          if (!(p != 0 && lane == ignore_lane)) ref_m[w][lane*8 +: 8] = v[b*8 +: 8];
        end
      end
      for (int k = 0; k < D; k++) begin
        v = faulty_read(ref_m[k], k);
        if (v != ideal_m[k]) begin
          code_q.push_back(code_of(p, 1));
          fin_q.push_back('{1'b0, k});
          return;
        end
      end
      code_q.push_back(code_of(p, 2));
    end
    fin_q.push_back('{1'b1, 0});
  endtask

  // Monitor: pops the scoreboard on every code change and on every rising done
  initial begin : monitor
    logic [15:0] prev_code;
    int          hold_len;
    logic        prev_done;
    fin_t        f;
    prev_code = '0;
    hold_len  = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge core_clk);
      if (!core_rstn) begin
        prev_code = '0;
        hold_len  = 0;
        prev_done = 1'b0;
      end else begin
        if (!mem_en && mem_we != 4'd0) we_wo_en++;
        if (done && mem_en) en_in_done++;
        if (checkbits != prev_code) begin
          if (prev_code != 16'h0)
            check("code_hold", (hold_len < HOLD) ? hold_len : HOLD, HOLD);
          if (code_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL code_seq: got %h expected no further code", checkbits);
          end else begin
            check("code_seq", checkbits, code_q.pop_front());
          end
          prev_code = checkbits;
          hold_len  = 1;
        end else begin
          hold_len++;
        end
        if (done && !prev_done) begin
          if (fin_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL done_result: got done=1 expected no completion");
          end else begin
            f = fin_q.pop_front();
            check("done_pass", pass, f.pass);
            check("done_fail_addr", fail_addr, f.addr);
            check("done_busy", busy, 0);
          end
        end
        prev_done = done;
      end
    end
  end

  initial begin : dut2_reads
    forever begin
      @(negedge core_clk);
      if (core_rstn && mem_en2) begin
        if (mem_addr2 != 1'b0) addr2_bad++;
        if (mem_we2 == 4'd0) begin
          case (checkbits2)
            16'hA040: rd2[0]++;
            16'hA020: rd2[1]++;
            16'hA010: rd2[2]++;
            default:  addr2_bad++;
          endcase
        end
      end
    end
  end

  task automatic clear_mem();
    @(negedge core_clk);
    mem_clr = 1'b1;
    @(negedge core_clk);
    mem_clr = 1'b0;
  endtask

  task automatic run(input bit spam);
    int cyc;
    @(negedge core_clk);
    start = 1'b1;
    @(posedge core_clk);
    #1;
    check("start_latency_code", checkbits, 16'hA040);
    check("start_busy", busy, 1);
    check("start_done_clr", done, 0);
    check("start_pass_clr", pass, 0);
    cyc = 0;
    while (busy && cyc < 20000) begin
      @(negedge core_clk);
      start = spam && busy;
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 20000) check("run_timeout", busy, 0);
    repeat (24) @(negedge core_clk);
  endtask

  task automatic set_faults(input int lane, input int sw, input int sb);
    ignore_lane = lane;
    stuck_word  = sw;
    stuck_bit   = sb;
  endtask

  initial begin : stim
    int cyc;
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int cyc;
    repeat (3) @(negedge core_clk);
    check("rst_checkbits", checkbits, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fail_addr", fail_addr, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    core_rstn = 1'b1;
    repeat (3) @(negedge core_clk);
    check("idle_checkbits", checkbits, 0);

    // Clean run
    set_faults(-1, -1, 0);
    clear_mem();
    predict();
    run(0);

    // Stuck-at-1 bit 3 of word 7, then a random stuck bit
    set_faults(-1, 7, 3);
    clear_mem();
    predict();
    run(0);
    check("stuck_done", done, 1);
    set_faults(-1, int'($urandom_range(0, D - 1)), int'($urandom_range(0, 31)));
    clear_mem();
    predict();
    run(0);

    // Byte lane 2 dropped on partial writes, then a random lane
    set_faults(2, -1, 0);
    clear_mem();
    predict();
    run(0);
    set_faults(int'($urandom_range(0, 3)), -1, 0);
    clear_mem();
    predict();
    run(0);

    // Reset during the byte write phase
    set_faults(-1, -1, 0);
    clear_mem();
    predict();
    @(negedge core_clk);
    start = 1'b1;
    @(negedge core_clk);
    start = 1'b0;
    cyc = 0;
    while (checkbits != 16'hA010 && cyc < 20000) begin
      @(negedge core_clk);
      cyc++;
    end
    check("reach_byte_phase", checkbits, 16'hA010);
    repeat (HOLD + $urandom_range(2, 2000)) @(negedge core_clk);
    #2;
    core_rstn = 1'b0;
    #1;
    check("midrst_mem_en", mem_en, 0);
    check("midrst_mem_we", mem_we, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_mem_wdata", mem_wdata, 0);
    check("midrst_checkbits", checkbits, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_pass", pass, 0);
    code_q.delete();
    fin_q.delete();
    repeat (2) @(negedge core_clk);
    #2;
    core_rstn = 1'b1;
    predict();
    run(0);

    // start held high throughout a run, then a fresh start straight from DONE
    predict();
    run(1);
    predict();
    run(0);

    // DEPTH=1, STATUS_HOLD=1 instance
    @(negedge core_clk);
    start2 = 1'b1;
    @(negedge core_clk);
    start2 = 1'b0;
    cyc = 1;
    while (!done2 && cyc < 40) begin
      @(negedge core_clk);
      cyc++;
    end
    check("d1_cycles_le30", (cyc <= 30) ? 0 : cyc, 0);
    check("d1_done", done2, 1);
    check("d1_pass", pass2, 1);
    check("d1_code", checkbits2, 16'hAB11);
    check("d1_fail_addr", fail_addr2, 0);
    check("d1_reads_word", rd2[0], 1);
    check("d1_reads_short", rd2[1], 1);
    check("d1_reads_byte", rd2[2], 1);
    check("d1_addr_bad", addr2_bad, 0);

    check("mem_en_after_done", en_in_done, 0);
    check("we_without_en", we_wo_en, 0);
    check("codes_left", code_q.size(), 0);
    check("results_left", fin_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
